// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, fetch states
// and the instruction-length rules used by the fetch stage.
package y86_pkg;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_REG,
    S_FETCH_CONST,
    S_PRESENT,
    S_HALT,
    S_ERROR
  } fetch_state_e;

  function automatic logic has_regids(input logic [3:0] icode);
    case (icode)
      IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
      IOPQ, IPUSHQ, IPOPQ: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic has_valc(input logic [3:0] icode);
    case (icode)
      IIRMOVQ, IRMMOVQ, IMRMOVQ,
      IJXX, ICALL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // nb is the constant width in bytes
  function automatic logic [7:0] instr_len(
    input logic [3:0] icode,
    input int         nb
  );
    logic [7:0] len;
    len = 8'd1;
    if (has_regids(icode)) len = len + 8'd1;
    if (has_valc(icode)) len = len + 8'(nb);
    return len;
  endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Memory read port and instruction handshake bundle
// between the fetch stage, instruction memory and decode.
interface instruction_fetcher_if #(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 64
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ack;
  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        icode_out;
  logic [3:0]        ifun_out;
  logic [3:0]        ra_out;
  logic [3:0]        rb_out;
  logic [WORD_W-1:0] valc_out;
  logic [WORD_W-1:0] valp_out;

  modport master (
    output mem_rd, mem_addr,
    input  mem_data, mem_ack,
    output instr_valid,
    input  instr_ready,
    output icode_out, ifun_out, ra_out, rb_out,
    output valc_out, valp_out
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_data, mem_ack,
    input  instr_valid,
    output instr_ready,
    input  icode_out, ifun_out, ra_out, rb_out,
    input  valc_out, valp_out
  );
endinterface

// File: rtl/y86_length_decode.sv
// Combinational length class of an icode: legality,
// register-byte and constant presence, total byte length.
module y86_length_decode
  import y86_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic [3:0] icode_i,
  output logic       valid_o,
  output logic       need_regids_o,
  output logic       need_valc_o,
  output logic [7:0] length_o
);

  assign valid_o       = (icode_i <= IPOPQ);
  assign need_regids_o = has_regids(icode_i);
  assign need_valc_o   = has_valc(icode_i);
  assign length_o      = instr_len(icode_i, WORD_W / 8);

endmodule

// File: rtl/instruction_fetcher.sv
// Byte-serial Y86-64 fetch: walks bytes from pc, builds
// icode/ifun/rA/rB/valC/valP and hands them to decode.
module instruction_fetcher
  import y86_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_W-1:0]     start_pc,
  instruction_fetcher_if.master bus,
  output logic                  instr_error,
  output logic                  halted
);

  localparam int NB = WORD_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] valc_q, valc_d;
  logic [WORD_W-1:0] valp_q, valp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q, ifun_d;
  logic [3:0]        ra_q, ra_d;
  logic [3:0]        rb_q, rb_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] off;
  logic              err_q, err_d;
  logic              halt_q, halt_d;

  logic [3:0] op_nib;
  logic       dec_valid;
  logic       dec_regids;
  logic       dec_valc;
  logic [7:0] dec_len;

  // The opcode byte is decoded as it arrives; afterwards the
  // latched icode drives the constant offset.
  assign op_nib = (state_q == S_FETCH_OP) ?
                  bus.mem_data[7:4] : icode_q;

  y86_length_decode #(.WORD_W(WORD_W)) u_len (
    .icode_i       (op_nib),
    .valid_o       (dec_valid),
    .need_regids_o (dec_regids),
    .need_valc_o   (dec_valc),
    .length_o      (dec_len)
  );

  // Next-state, assembly and registered request logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    rd_d    = rd_q;
    err_d   = err_q;
    halt_d  = halt_q;
    if (start) begin
      state_d = S_FETCH_OP;
      pc_d    = start_pc;
      cnt_d   = '0;
      rd_d    = 1'b0;
      err_d   = 1'b0;
      halt_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH_OP: begin
          if (!rd_q) begin
            rd_d = 1'b1;
          end else if (bus.mem_ack) begin
            icode_d = bus.mem_data[7:4];
            ifun_d  = bus.mem_data[3:0];
            ra_d    = RNONE;
            rb_d    = RNONE;
            valc_d  = '0;
            valp_d  = pc_q + WORD_W'(dec_len);
            cnt_d   = '0;
            if (!dec_valid) begin
              state_d = S_ERROR;
              rd_d    = 1'b0;
              err_d   = 1'b1;
            end else if (dec_regids) begin
              state_d = S_FETCH_REG;
            end else if (dec_valc) begin
              state_d = S_FETCH_CONST;
            end else begin
              state_d = S_PRESENT;
              rd_d    = 1'b0;
            end
          end
        end
        S_FETCH_REG: begin
          if (!rd_q) begin
            rd_d = 1'b1;
          end else if (bus.mem_ack) begin
            ra_d = bus.mem_data[7:4];
            rb_d = bus.mem_data[3:0];
            if (dec_valc) begin
              state_d = S_FETCH_CONST;
            end else begin
              state_d = S_PRESENT;
              rd_d    = 1'b0;
            end
          end
        end
        S_FETCH_CONST: begin
          if (!rd_q) begin
            rd_d = 1'b1;
          end else if (bus.mem_ack) begin
            valc_d[{cnt_q, 3'b000} +: 8] = bus.mem_data;
            if (cnt_q == CW'(NB - 1)) begin
              state_d = S_PRESENT;
              rd_d    = 1'b0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_PRESENT: begin
          if (bus.instr_ready) begin
            pc_d = valp_q;
            if (icode_q == IHALT) begin
              state_d = S_HALT;
              halt_d  = 1'b1;
            end else begin
              state_d = S_FETCH_OP;
            end
          end
        end
        default: ;
      endcase
    end
    off = '0;
    if (state_d == S_FETCH_REG) begin
      off = ADDR_W'(1);
    end else if (state_d == S_FETCH_CONST) begin
      off = ADDR_W'(dec_regids ? 2 : 1) + ADDR_W'(cnt_d);
    end
    addr_d = rd_d ? (pc_d[ADDR_W-1:0] + off) : addr_q;
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= RNONE;
      rb_q    <= RNONE;
      valc_q  <= '0;
      valp_q  <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
    end
  end

  assign bus.mem_rd      = rd_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = (state_q == S_PRESENT);
  assign bus.icode_out   = icode_q;
  assign bus.ifun_out    = ifun_q;
  assign bus.ra_out      = ra_q;
  assign bus.rb_out      = rb_q;
  assign bus.valc_out    = valc_q;
  assign bus.valp_out    = valp_q;
  assign instr_error     = err_q;
  assign halted          = halt_q;

endmodule
